// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: button edge detection, run/pause/lap FSM,
// BCD mm:ss accumulation of timer ticks and registered display digits.
module stopwatch_ctrl #(
  parameter int MAX_MIN_TENS = 5
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  input  logic       ten_sec_mode,
  input  logic       second_tick,
  output logic       timer_enable,
  output logic       ten_sec_enable,
  output logic [1:0] state,
  output logic [2:0] disp_min_tens,
  output logic [3:0] disp_min_ones,
  output logic [2:0] disp_sec_tens,
  output logic [3:0] disp_sec_ones,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  localparam logic [2:0] MAX_MT = 3'(MAX_MIN_TENS);

  state_t      state_r;
  state_t      state_next_s;
  logic        start_prev_r;
  logic        lap_prev_r;
  logic        clear_prev_r;
  logic        tick_prev_r;
  logic        start_edge_s;
  logic        clear_edge_s;
  logic        lap_edge_s;
  logic        tick_edge_s;
  logic        counting_s;
  logic        lap_capture_s;
  logic        clear_count_s;
  logic [13:0] count_r;
  logic [13:0] lap_count_r;
  logic [13:0] count_next_s;
  logic        overflow_next_s;
  logic [14:0] inc_s;
  logic [13:0] shown_s;

  // Packed count layout is {min_tens, min_ones, sec_tens, sec_ones}; bit 14 flags wrap.
  function automatic logic [14:0] bcd_inc(input logic [13:0] cnt, input logic ten);
    logic [2:0] mt;
    logic [3:0] mo;
    logic [2:0] st;
    logic [3:0] so;
    logic       carry;
    logic       wrap;
    {mt, mo, st, so} = cnt;
    wrap = 1'b0;
    if (ten) begin
      carry = 1'b1;
    end else if (so == 4'd9) begin
      so    = 4'd0;
      carry = 1'b1;
    end else begin
      so    = so + 4'd1;
      carry = 1'b0;
    end
    if (carry) begin
      if (st == 3'd5) begin
        st = 3'd0;
      end else begin
        st    = st + 3'd1;
        carry = 1'b0;
      end
    end else begin
      carry = 1'b0;
    end
    if (carry) begin
      if (mo == 4'd9) begin
        mo = 4'd0;
      end else begin
        mo    = mo + 4'd1;
        carry = 1'b0;
      end
    end else begin
      carry = 1'b0;
    end
    if (carry) begin
      if (mt == MAX_MT) begin
        {mt, mo, st, so} = 14'd0;
        wrap = 1'b1;
      end else begin
        mt = mt + 3'd1;
      end
    end else begin
      wrap = 1'b0;
    end
    return {wrap, mt, mo, st, so};
  endfunction

  assign start_edge_s = start_stop & ~start_prev_r;
  assign clear_edge_s = clear & ~clear_prev_r & ~start_edge_s;
  assign lap_edge_s   = lap & ~lap_prev_r & ~start_edge_s & ~(clear & ~clear_prev_r);
  assign tick_edge_s  = second_tick & ~tick_prev_r;
  assign counting_s   = (state_r == RUN) || (state_r == LAP);
  assign inc_s        = bcd_inc(count_r, ten_sec_enable);
  assign shown_s      = (state_r == LAP) ? lap_count_r : count_r;
  assign state        = state_r;

  // Next-state decode plus the lap-capture and clear strobes it implies.
  always_comb begin
    state_next_s  = state_r;
    lap_capture_s = 1'b0;
    clear_count_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_edge_s) state_next_s = RUN;
        else              state_next_s = IDLE;
      end
      RUN: begin
        if (start_edge_s) begin
          state_next_s = PAUSE;
        end else if (lap_edge_s) begin
          state_next_s  = LAP;
          lap_capture_s = 1'b1;
        end else begin
          state_next_s = RUN;
        end
      end
      LAP: begin
        if (start_edge_s)    state_next_s = PAUSE;
        else if (lap_edge_s) state_next_s = RUN;
        else                 state_next_s = LAP;
      end
      PAUSE: begin
        if (start_edge_s) begin
          state_next_s = RUN;
        end else if (clear_edge_s) begin
          state_next_s  = IDLE;
          clear_count_s = 1'b1;
        end else begin
          state_next_s = PAUSE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Live count and sticky overflow; clear only arrives in PAUSE, when no tick counts.
  always_comb begin
    count_next_s    = count_r;
    overflow_next_s = overflow;
    if (clear_count_s) begin
      count_next_s    = 14'd0;
      overflow_next_s = 1'b0;
    end else if (counting_s && tick_edge_s) begin
      count_next_s    = inc_s[13:0];
      overflow_next_s = overflow | inc_s[14];
    end else begin
      count_next_s    = count_r;
      overflow_next_s = overflow;
    end
  end

  // State, edge-detect history, timer enable and latched period select.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_r        <= IDLE;
      start_prev_r   <= 1'b0;
      lap_prev_r     <= 1'b0;
      clear_prev_r   <= 1'b0;
      tick_prev_r    <= 1'b0;
      timer_enable   <= 1'b0;
      ten_sec_enable <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      start_prev_r <= start_stop;
      lap_prev_r   <= lap;
      clear_prev_r <= clear;
      tick_prev_r  <= second_tick;
      timer_enable <= (state_next_s == RUN) || (state_next_s == LAP);
      if (state_r == IDLE) ten_sec_enable <= ten_sec_mode;
      else                 ten_sec_enable <= ten_sec_enable;
    end
  end

  // Count, lap snapshot and overflow registers.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      count_r     <= 14'd0;
      lap_count_r <= 14'd0;
      overflow    <= 1'b0;
    end else begin
      count_r  <= count_next_s;
      overflow <= overflow_next_s;
      if (lap_capture_s) lap_count_r <= count_r;
      else               lap_count_r <= lap_count_r;
    end
  end

  // Display digits follow the count/state one cycle later.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      disp_min_tens <= 3'd0;
      disp_min_ones <= 4'd0;
      disp_sec_tens <= 3'd0;
      disp_sec_ones <= 4'd0;
    end else begin
      {disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones} <= shown_s;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios followed by random
// button/tick traffic, compared every cycle against a seconds-based reference model.
module tb_stopwatch_ctrl;
  localparam int MAXMT = 5;
  localparam int LIM   = (MAXMT + 1) * 600;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic       ten_sec_mode = 1'b0, second_tick = 1'b0;
  logic       timer_enable, ten_sec_enable, overflow;
  logic [1:0] state;
  logic [2:0] disp_min_tens, disp_sec_tens;
  logic [3:0] disp_min_ones, disp_sec_ones;

  int checks = 0;
  int errors = 0;

  // Reference model: count held as plain elapsed seconds.
  int m_state, m_sec, m_lap, m_disp;
  bit m_ovf, m_ten, m_te, p_ss, p_cl, p_lp, p_tk;

  stopwatch_ctrl #(.MAX_MIN_TENS(MAXMT)) dut (
    .clk(clk), .n_rst(n_rst), .start_stop(start_stop), .lap(lap), .clear(clear),
    .ten_sec_mode(ten_sec_mode), .second_tick(second_tick),
    .timer_enable(timer_enable), .ten_sec_enable(ten_sec_enable), .state(state),
    .disp_min_tens(disp_min_tens), .disp_min_ones(disp_min_ones),
    .disp_sec_tens(disp_sec_tens), .disp_sec_ones(disp_sec_ones), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] digits(input int s);
    logic [2:0] mt; logic [3:0] mo; logic [2:0] st; logic [3:0] so;
    mt = 3'(s / 600);
    mo = 4'((s / 60) % 10);
    st = 3'((s % 60) / 10);
    so = 4'(s % 10);
    return {mt, mo, st, so};
  endfunction

  function automatic logic [18:0] model_vec();
    return {m_ovf, m_te, m_ten, 2'(m_state), digits(m_disp)};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {overflow, timer_enable, ten_sec_enable, state,
            disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones};
  endfunction

  function automatic logic [13:0] dut_disp();
    return {disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_sec = 0; m_lap = 0; m_disp = 0;
    m_ovf = 0; m_ten = 0; m_te = 0;
    p_ss = 0; p_cl = 0; p_lp = 0; p_tk = 0;
  endtask

  task automatic model_update();
    bit se, ce, le, te, running;
    int old_sec, old_state;
    se = start_stop && !p_ss;
    ce = clear && !p_cl && !se;
    le = lap && !p_lp && !se && !(clear && !p_cl);
    te = second_tick && !p_tk;
    old_sec = m_sec; old_state = m_state;
    running = (old_state == 1) || (old_state == 3);
    m_disp = (old_state == 3) ? m_lap : old_sec;
    if (running && te) begin
      m_sec = m_sec + (m_ten ? 10 : 1);
      if (m_sec >= LIM) begin m_sec = 0; m_ovf = 1; end
    end
    case (old_state)
      0: if (se) m_state = 1;
      1: if (se) m_state = 2; else if (le) begin m_state = 3; m_lap = old_sec; end
      3: if (se) m_state = 2; else if (le) m_state = 1;
      2: if (se) m_state = 1; else if (ce) begin m_state = 0; m_sec = 0; m_ovf = 0; end
      default: m_state = 0;
    endcase
    if (old_state == 0) m_ten = ten_sec_mode;
    m_te = (m_state == 1) || (m_state == 3);
    p_ss = start_stop; p_cl = clear; p_lp = lap; p_tk = second_tick;
  endtask

  task automatic step();
    @(posedge clk);
    if (n_rst) model_reset();
    else model_update();
    #1;
    chk("cycle", 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      second_tick = 1'b1; step();
      second_tick = 1'b0; step();
    end
  endtask

  task automatic press_start();
    start_stop = 1'b1; step();
    start_stop = 1'b0; step();
  endtask

  task automatic press_lap();
    lap = 1'b1; step();
    lap = 1'b0; step();
  endtask

  task automatic press_clear();
    clear = 1'b1; step();
    clear = 1'b0; step();
  endtask

  initial begin
    model_reset();
    steps(2);
    chk("reset_state", 32'(dut_vec()), 32'd0);
    n_rst = 1'b0;
    step();

    // Start edge: RUN and timer enabled one edge later.
    start_stop = 1'b1; step();
    chk("start_state", 32'(state), 32'd1);
    chk("start_ten", 32'(timer_enable), 32'd1);
    start_stop = 1'b0; step();
    tick(3);
    chk("disp_0003", 32'(dut_disp()), 32'({3'd0, 4'd0, 3'd0, 4'd3}));

    // Lap freeze at 00:12 while live count reaches 00:17.
    tick(9);
    press_lap();
    tick(5);
    chk("lap_frozen", 32'(dut_disp()), 32'({3'd0, 4'd0, 3'd1, 4'd2}));
    chk("lap_state", 32'(state), 32'd3);
    press_lap();
    chk("lap_release", 32'(dut_disp()), 32'({3'd0, 4'd0, 3'd1, 4'd7}));

    // 00:59 -> 01:00 carry.
    tick(42);
    chk("disp_0059", 32'(dut_disp()), 32'({3'd0, 4'd0, 3'd5, 4'd9}));
    tick(1);
    chk("disp_0100", 32'(dut_disp()), 32'({3'd0, 4'd1, 3'd0, 4'd0}));

    // Tick held high across pause/resume is not recounted.
    press_start();
    second_tick = 1'b1; steps(3);
    press_start();
    steps(3);
    second_tick = 1'b0; steps(2);
    chk("held_tick", 32'(dut_disp()), 32'({3'd0, 4'd1, 3'd0, 4'd0}));

    // Simultaneous start+clear+lap in PAUSE resumes only.
    press_start();
    start_stop = 1'b1; clear = 1'b1; lap = 1'b1; step();
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0; step();
    chk("prio_state", 32'(state), 32'd1);
    chk("prio_count", 32'(dut_disp()), 32'({3'd0, 4'd1, 3'd0, 4'd0}));

    // Held start acts once.
    start_stop = 1'b1; steps(10);
    start_stop = 1'b0; step();
    chk("held_start", 32'(state), 32'd2);
    press_clear();
    chk("clear_idle", 32'(dut_vec()), 32'd0);

    // Full wrap past 59:59.
    press_start();
    tick(LIM - 1);
    chk("disp_5959", 32'(dut_disp()), 32'({3'd5, 4'd9, 3'd5, 4'd9}));
    tick(1);
    chk("wrap_disp", 32'(dut_disp()), 32'd0);
    chk("wrap_ovf", 32'(overflow), 32'd1);
    tick(2);
    press_start();
    chk("ovf_pause", 32'(overflow), 32'd1);
    press_start(); press_start();
    press_clear();
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Ten-second mode latched only in IDLE.
    ten_sec_mode = 1'b1; step();
    press_start();
    tick(7);
    chk("ten_0110", 32'(dut_disp()), 32'({3'd0, 4'd1, 3'd1, 4'd0}));
    ten_sec_mode = 1'b0; steps(3);
    chk("ten_latched", 32'(ten_sec_enable), 32'd1);
    tick(1);
    chk("ten_0120", 32'(dut_disp()), 32'({3'd0, 4'd1, 3'd2, 4'd0}));

    // Asynchronous reset mid-RUN.
    #2 n_rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst", 32'(dut_vec()), 32'd0);
    step();
    n_rst = 1'b0;
    step();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start_stop  = ($urandom_range(0, 19) == 0);
      lap         = ($urandom_range(0, 7) == 0);
      clear       = ($urandom_range(0, 9) == 0);
      second_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) ten_sec_mode = ~ten_sec_mode;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
